// File: rtl/spio_hss_multiplexer_pkt_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : spio_hss_multiplexer_pkt_gen_if
//  Purpose  : Packet bus between the SpiNNaker packet source and its sink.
//             Carries NUM_CHANS 72-bit {pld,key,hdr} streams, each with its
//             own valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface spio_hss_multiplexer_pkt_gen_if #(
  parameter int NUM_CHANS = 8
);
  logic [72*NUM_CHANS-1:0] pkt_data;
  logic [NUM_CHANS-1:0]    pkt_vld;
  logic [NUM_CHANS-1:0]    pkt_rdy;

  // Packet source side
  modport master (
    output pkt_data,
    output pkt_vld,
    input  pkt_rdy
  );

  // Packet sink side
  modport slave (
    input  pkt_data,
    input  pkt_vld,
    output pkt_rdy
  );
endinterface
`default_nettype wire

// File: rtl/spio_hss_multiplexer_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spio_hss_multiplexer_pkt_gen
//  Purpose  : Multi-channel deterministic SpiNNaker packet source. Each
//             channel emits keys KEY_INIT + ch*KEY_STRIDE + seq with payload
//             PLD_INIT ^ key, in continuous, burst, random-gap or hold mode,
//             with per-channel enable and packet-count limits.
//  Revision : 1.0  initial release
// ============================================================================
module spio_hss_multiplexer_pkt_gen #(
  parameter int          NUM_CHANS  = 8,
  parameter logic [31:0] KEY_INIT   = 32'h0000_0001,
  parameter logic [31:0] KEY_STRIDE = 32'h0001_0000,
  parameter logic [31:0] PLD_INIT   = 32'ha5a5_a5a5,
  parameter int          CNT_BITS   = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                          tbs_clk,
  input  logic                          tbs_rst,
  input  logic                          start,
  input  logic [NUM_CHANS-1:0]          cfg_en,
  input  logic [1:0]                    cfg_mode,
  input  logic [7:0]                    cfg_burst,
  input  logic [7:0]                    cfg_gap,
  input  logic [CNT_BITS-1:0]           cfg_limit,
  spio_hss_multiplexer_pkt_gen_if.master pkt,
  output logic [CNT_BITS*NUM_CHANS-1:0] sent_cnt,
  output logic                          busy,
  output logic                          done
);

  // Traffic modes
  localparam logic [1:0] MODE_CONT  = 2'd0;
  localparam logic [1:0] MODE_BURST = 2'd1;
  localparam logic [1:0] MODE_RAND  = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [15:0]          lfsr;
  logic [NUM_CHANS-1:0] active;
  logic [NUM_CHANS-1:0] is_done;
  logic                 start_ok;
  logic [7:0]           burst_eff;
  logic                 run_req;

  // A start is only honoured when no channel is mid-run; the state check
  // closes the one-cycle window before the registered busy flag rises.
  assign start_ok  = start & ~busy & ~(|active);
  // A burst length of zero behaves as a single-packet burst.
  assign burst_eff = (cfg_burst == 8'd0) ? 8'd1 : cfg_burst;
  // Any mode other than hold wants a packet offered.
  assign run_req   = (cfg_mode != MODE_HOLD);

  // Shared random-gap source: free-running Galois LFSR, re-seeded by start.
  always_ff @(posedge tbs_clk or posedge tbs_rst) begin
    if (tbs_rst) begin
      lfsr <= LFSR_SEED;
    end else if (start_ok) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Run status: busy tracks active channels, done flags a completed run.
  always_ff @(posedge tbs_clk or posedge tbs_rst) begin
    if (tbs_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= |active;
      done <= start_ok ? 1'b0 : (&is_done);
    end
  end

  for (genvar i = 0; i < NUM_CHANS; i++) begin : g_chan
    localparam logic [31:0] KEY_START = KEY_INIT + KEY_STRIDE * 32'(i);
    // LFSR bits feeding this channel's 3-bit random gap
    localparam int B0 = i % 16;
    localparam int B1 = (i + 1) % 16;
    localparam int B2 = (i + 2) % 16;

    state_t              state;
    logic                vld;
    logic [31:0]         key;
    logic [31:0]         pld;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_inc;
    logic [7:0]          bcnt;
    logic [7:0]          gcnt;
    logic [7:0]          burst_l;
    logic [1:0]          mode_l;
    logic                xfer;
    logic                lim_hit;
    logic [2:0]          rgap;

    assign xfer    = vld & pkt.pkt_rdy[i];
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_BITS'(1);
    assign lim_hit = (cfg_limit != '0) && (cnt_inc == cfg_limit);
    assign rgap    = {lfsr[B2], lfsr[B1], lfsr[B0]};
    assign pld     = PLD_INIT ^ key;

    assign pkt.pkt_data[72*i +: 72]          = {pld, key, 7'b0000001, ^(key ^ pld)};
    assign pkt.pkt_vld[i]                    = vld;
    assign sent_cnt[CNT_BITS*i +: CNT_BITS]  = cnt;
    assign active[i]  = (state == ST_SEND) || (state == ST_GAP);
    assign is_done[i] = (state == ST_DONE);

    // Per-channel sequencer. mode_l/burst_l hold the mode and burst size in
    // force for the current burst; they are refreshed only at boundaries so a
    // burst in flight is never cut short by a configuration change.
    always_ff @(posedge tbs_clk or posedge tbs_rst) begin
      if (tbs_rst) begin
        state   <= ST_IDLE;
        vld     <= 1'b0;
        key     <= KEY_START;
        cnt     <= '0;
        bcnt    <= 8'd0;
        gcnt    <= 8'd0;
        mode_l  <= MODE_CONT;
        burst_l <= 8'd1;
      end else if (start_ok) begin
        key     <= KEY_START;
        cnt     <= '0;
        bcnt    <= 8'd0;
        gcnt    <= 8'd0;
        mode_l  <= cfg_mode;
        burst_l <= burst_eff;
        if (cfg_en[i]) begin
          state <= ST_SEND;
          vld   <= run_req;
        end else begin
          state <= ST_DONE;
          vld   <= 1'b0;
        end
      end else begin
        case (state)
          ST_SEND: begin
            if (xfer) begin
              key <= key + 32'd1;
              cnt <= cnt_inc;
              if (lim_hit || !cfg_en[i]) begin
                state <= ST_DONE;
                vld   <= 1'b0;
              end else begin
                case (mode_l)
                  MODE_BURST: begin
                    if (bcnt >= burst_l - 8'd1) begin
                      bcnt    <= 8'd0;
                      mode_l  <= cfg_mode;
                      burst_l <= burst_eff;
                      if (cfg_gap != 8'd0) begin
                        state <= ST_GAP;
                        gcnt  <= cfg_gap;
                        vld   <= 1'b0;
                      end else begin
                        vld   <= run_req;
                      end
                    end else begin
                      bcnt <= bcnt + 8'd1;
                    end
                  end
                  MODE_RAND: begin
                    mode_l  <= cfg_mode;
                    burst_l <= burst_eff;
                    if (rgap != 3'd0) begin
                      state <= ST_GAP;
                      gcnt  <= {5'd0, rgap};
                      vld   <= 1'b0;
                    end else begin
                      vld   <= run_req;
                    end
                  end
                  default: begin
                    // Continuous, or a hold that arrived while a packet was
                    // pending: every packet is a boundary.
                    mode_l  <= cfg_mode;
                    burst_l <= burst_eff;
                    vld     <= run_req;
                  end
                endcase
              end
            end else if (!vld) begin
              // Frozen in hold: leave on disable, resume when hold is lifted.
              if (!cfg_en[i]) begin
                state <= ST_DONE;
              end else begin
                mode_l  <= cfg_mode;
                burst_l <= burst_eff;
                vld     <= run_req;
              end
            end
          end
          ST_GAP: begin
            if (!cfg_en[i]) begin
              state <= ST_DONE;
            end else if (gcnt <= 8'd1) begin
              state   <= ST_SEND;
              mode_l  <= cfg_mode;
              burst_l <= burst_eff;
              vld     <= run_req;
            end else begin
              gcnt <= gcnt - 8'd1;
            end
          end
          default: begin
            // IDLE and DONE wait for the next start with vld low.
            vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spio_hss_multiplexer_pkt_gen
//  Purpose  : Directed self-checking bench for the multi-channel packet
//             source: reset, continuous, backpressure, burst, random gap,
//             enable drop and mid-run reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spio_hss_multiplexer_pkt_gen;

  logic         tbs_clk;
  logic         tbs_rst;
  logic         start;
  logic [7:0]   cfg_en;
  logic [1:0]   cfg_mode;
  logic [7:0]   cfg_burst;
  logic [7:0]   cfg_gap;
  logic [15:0]  cfg_limit;
  logic [127:0] sent_cnt;
  logic         busy;
  logic         done;

  int n_chk;
  int n_err;

  spio_hss_multiplexer_pkt_gen_if #(.NUM_CHANS(8)) pkt_if ();

  spio_hss_multiplexer_pkt_gen dut (
    .tbs_clk   (tbs_clk),
    .tbs_rst   (tbs_rst),
    .start     (start),
    .cfg_en    (cfg_en),
    .cfg_mode  (cfg_mode),
    .cfg_burst (cfg_burst),
    .cfg_gap   (cfg_gap),
    .cfg_limit (cfg_limit),
    .pkt       (pkt_if),
    .sent_cnt  (sent_cnt),
    .busy      (busy),
    .done      (done)
  );

  logic [71:0] d0;
  logic [71:0] d7;
  logic [15:0] s0;
  logic [15:0] s1;
  logic [15:0] s7;
  assign d0 = pkt_if.pkt_data[71:0];
  assign d7 = pkt_if.pkt_data[575:504];
  assign s0 = sent_cnt[15:0];
  assign s1 = sent_cnt[31:16];
  assign s7 = sent_cnt[127:112];

  // 100 MHz clock
  initial begin
    tbs_clk = 1'b0;
    forever #5 tbs_clk = ~tbs_clk;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tbs_clk);
    #1;
  endtask

  function automatic logic [71:0] exp_data(input logic [31:0] k);
    logic [31:0] p;
    p = k ^ 32'hA5A5_A5A5;
    return {p, k, 7'b0000001, ^(k ^ p)};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] m);
    return {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_all(input string p);
    cfg_en = 8'h00;
    pkt_if.pkt_rdy = 8'hFF;
    repeat (3) tick();
    check_eq({p, "_stop_done"}, done, 1);
  endtask

  // Continuous mode on ch0 and ch7, limit 4
  task automatic run_t1(input string p);
    cfg_en = 8'h81; cfg_mode = 2'd0; cfg_burst = 8'd1; cfg_gap = 8'd0;
    cfg_limit = 16'd4; pkt_if.pkt_rdy = 8'hFF;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check_eq({p, "_vld"}, pkt_if.pkt_vld, 8'h81);
      check_eq({p, "_d0"}, d0, exp_data(32'h1 + 32'(k)));
      check_eq({p, "_d7"}, d7, exp_data(32'h70001 + 32'(k)));
      tick();
    end
    check_eq({p, "_vld_end"}, pkt_if.pkt_vld, 8'h00);
    check_eq({p, "_sent0"}, s0, 16'd4);
    check_eq({p, "_sent7"}, s7, 16'd4);
    check_eq({p, "_sent1"}, s1, 16'd0);
    tick();
    check_eq({p, "_done"}, done, 1);
    check_eq({p, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] exp_key;
    logic [15:0] m;
    int          idle;
    int          npk;
    int          exp_gap;

    n_chk = 0; n_err = 0;
    tbs_rst = 1'b1; start = 1'b0; cfg_en = 8'h00; cfg_mode = 2'd0;
    cfg_burst = 8'd1; cfg_gap = 8'd0; cfg_limit = 16'd0; pkt_if.pkt_rdy = 8'h00;

    // Reset state
    repeat (3) tick();
    check_eq("rst_vld", pkt_if.pkt_vld, 8'h00);
    check_eq("rst_sent", sent_cnt, 128'd0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_d0", d0, exp_data(32'h1));
    check_eq("rst_d7", d7, exp_data(32'h70001));
    tbs_rst = 1'b0;
    tick();

    // 1: continuous with limit
    run_t1("t1");

    // 2: backpressure on ch0 holds the first packet
    cfg_en = 8'h01; cfg_mode = 2'd0; cfg_limit = 16'd0; pkt_if.pkt_rdy = 8'h00;
    pulse_start();
    for (int j = 0; j < 5; j++) begin
      check_eq("t2_vld", pkt_if.pkt_vld[0], 1);
      check_eq("t2_hold", d0, exp_data(32'h1));
      tick();
    end
    pkt_if.pkt_rdy = 8'h01;
    check_eq("t2_pre", d0, exp_data(32'h1));
    tick();
    pkt_if.pkt_rdy = 8'h00;
    check_eq("t2_next", d0, exp_data(32'h2));
    check_eq("t2_vld2", pkt_if.pkt_vld[0], 1);
    tick();

    // 5: drop enable while a packet is pending
    cfg_en = 8'h00;
    for (int j = 0; j < 3; j++) begin
      check_eq("t5_vld", pkt_if.pkt_vld[0], 1);
      check_eq("t5_hold", d0, exp_data(32'h2));
      tick();
    end
    pkt_if.pkt_rdy = 8'h01;
    tick();
    check_eq("t5_vld_off", pkt_if.pkt_vld[0], 0);
    check_eq("t5_sent", s0, 16'd2);
    tick();
    check_eq("t5_done", done, 1);
    check_eq("t5_busy", busy, 0);
    tick();
    check_eq("t5_sent_final", s0, 16'd2);

    // 3: burst 3, gap 2 -> 1,1,1,0,0 with contiguous keys
    cfg_en = 8'h01; cfg_mode = 2'd1; cfg_burst = 8'd3; cfg_gap = 8'd2;
    cfg_limit = 16'd0; pkt_if.pkt_rdy = 8'hFF;
    pulse_start();
    exp_key = 32'h1;
    for (int c = 0; c < 15; c++) begin
      check_eq("t3_vld", pkt_if.pkt_vld[0], ((c % 5) < 3) ? 1'b1 : 1'b0);
      if (pkt_if.pkt_vld[0]) begin
        check_eq("t3_key", d0, exp_data(exp_key));
        exp_key = exp_key + 32'd1;
      end
      if (c == 1) check_eq("t3_busy", busy, 1);
      tick();
    end
    stop_all("t3");

    // 4: random gap on ch0 against a reference LFSR
    cfg_en = 8'h01; cfg_mode = 2'd2; cfg_limit = 16'd0; pkt_if.pkt_rdy = 8'hFF;
    pulse_start();
    m = 16'hACE1; exp_key = 32'h1; idle = 0; npk = 0; exp_gap = 0;
    for (int cyc = 0; cyc < 2000 && npk < 64; cyc++) begin
      if (pkt_if.pkt_vld[0]) begin
        if (npk > 0) check_eq("t4_gap", 128'(idle), 128'(exp_gap));
        check_eq("t4_key", d0, exp_data(exp_key));
        exp_key = exp_key + 32'd1;
        exp_gap = int'(m[2:0]);
        idle = 0;
        npk++;
      end else begin
        idle++;
      end
      tick();
      m = lfsr_adv(m);
    end
    if (npk < 64) check_eq("t4_budget", 128'(npk), 128'd64);
    stop_all("t4");

    // 6: reset in the middle of a burst, then replay test 1
    cfg_en = 8'hFF; cfg_mode = 2'd1; cfg_burst = 8'd3; cfg_gap = 8'd2;
    cfg_limit = 16'd0; pkt_if.pkt_rdy = 8'hFF;
    pulse_start();
    tick();
    check_eq("t6_pre_sent", s0, 16'd1);
    #2 tbs_rst = 1'b1;
    #1;
    check_eq("t6_vld", pkt_if.pkt_vld, 8'h00);
    check_eq("t6_sent", sent_cnt, 128'd0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    tick();
    tick();
    tbs_rst = 1'b0;
    tick();
    run_t1("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
